// File: rtl/up_pkg.sv
// Shared encodings for the up interrupt controller: FSM states and config register addresses.
package up_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SERV = 2'd2
   } st_e;

   localparam logic [1:0] ADDR_MASK   = 2'd0;
   localparam logic [1:0] ADDR_MODE   = 2'd1;
   localparam logic [1:0] ADDR_PEND   = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

endpackage

// File: rtl/up_int_sync.sv
// Multi-stage synchroniser for the async request lines plus a registered rising-edge detector.
module up_int_sync #(
   parameter int N_IRQ       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             nrst_i,
   input  logic [N_IRQ-1:0] irq_i,
   output logic [N_IRQ-1:0] s_o,
   output logic [N_IRQ-1:0] rise_o
);

   logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
   logic [N_IRQ-1:0] prev_q;
   logic [N_IRQ-1:0] rise_q;

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q <= '0;
         rise_q <= '0;
      end else begin
         sync_q[0] <= irq_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync_q[SYNC_STAGES-1];
         // Registered so the edge path lands on PEND one cycle after detection.
         rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   assign s_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = rise_q;

endmodule

// File: rtl/up_int_ctrl.sv
// Interrupt controller for the up core: synchronise, latch/track, mask, prioritise, and hand one
// interrupt at a time to the core through an int/int_ack/eoi handshake.
//
// state   | meaning
// IDLE    | nothing requested, waiting for an eligible line
// REQ     | int high, int_vec frozen, waiting for int_ack (or withdraw)
// SERV    | core servicing int_vec, waiting for eoi
module up_int_ctrl
   import up_pkg::*;
#(
   parameter int N_IRQ       = 8,
   parameter int VEC_W       = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             nrst_i,
   input  logic [N_IRQ-1:0] irq_i,
   input  logic             cfg_we_i,
   input  logic [1:0]       cfg_addr_i,
   input  logic [N_IRQ-1:0] cfg_wdata_i,
   output logic [N_IRQ-1:0] cfg_rdata_o,
   output logic             int_o,
   output logic [VEC_W-1:0] int_vec_o,
   input  logic             int_ack_i,
   input  logic             eoi_i
);

   logic [N_IRQ-1:0] mask_q, mask_d;
   logic [N_IRQ-1:0] mode_q, mode_d;
   logic [N_IRQ-1:0] pend_q, pend_d;
   logic [N_IRQ-1:0] s, rise;
   logic [N_IRQ-1:0] pend_view, eligible;
   logic [VEC_W-1:0] vec_q, vec_d, winner;
   logic             int_q, int_d;
   st_e              state_q, state_d;
   logic             wr_mask, wr_mode, wr_pend, ack_take;

   function automatic logic [VEC_W-1:0] prio_enc(input logic [N_IRQ-1:0] req);
      logic [VEC_W-1:0] idx;
      idx = '0;
      for (int i = N_IRQ-1; i >= 0; i--) begin
         if (req[i]) idx = VEC_W'(i);
      end
      return idx;
   endfunction

   up_int_sync #(
      .N_IRQ       (N_IRQ),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i  (clk_i),
      .nrst_i (nrst_i),
      .irq_i  (irq_i),
      .s_o    (s),
      .rise_o (rise)
   );

   assign wr_mask  = cfg_we_i && (cfg_addr_i == ADDR_MASK);
   assign wr_mode  = cfg_we_i && (cfg_addr_i == ADDR_MODE);
   assign wr_pend  = cfg_we_i && (cfg_addr_i == ADDR_PEND);
   assign ack_take = (state_q == ST_REQ) && int_ack_i;

   // Level lines are never stored; their PEND view follows the synchronised input directly.
   assign pend_view = (pend_q & mode_q) | (s & ~mode_q);
   assign eligible  = pend_view & mask_q;
   assign winner    = prio_enc(eligible);

   always_comb begin
      mask_d = wr_mask ? cfg_wdata_i : mask_q;
      mode_d = wr_mode ? cfg_wdata_i : mode_q;
      pend_d = pend_q;
      if (wr_mode)  pend_d = pend_d & ~(mode_q ^ cfg_wdata_i);
      if (wr_pend)  pend_d = pend_d & ~cfg_wdata_i;
      if (ack_take) pend_d = pend_d & ~(N_IRQ'(1) << vec_q);
      // Set is applied last so a new edge always survives a same-cycle clear.
      pend_d = (pend_d | (rise & mode_q)) & mode_d;
   end

   always_comb begin
      state_d = state_q;
      int_d   = int_q;
      vec_d   = vec_q;
      unique case (state_q)
         ST_IDLE: begin
            int_d = 1'b0;
            if (|eligible) begin
               state_d = ST_REQ;
               int_d   = 1'b1;
               vec_d   = winner;
            end
         end
         ST_REQ: begin
            if (int_ack_i) begin
               state_d = ST_SERV;
               int_d   = 1'b0;
            end else if (!eligible[vec_q]) begin
               state_d = ST_IDLE;
               int_d   = 1'b0;
            end
         end
         ST_SERV: begin
            int_d = 1'b0;
            if (eoi_i) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            int_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         mask_q  <= '0;
         mode_q  <= '0;
         pend_q  <= '0;
         state_q <= ST_IDLE;
         int_q   <= 1'b0;
         vec_q   <= '0;
      end else begin
         mask_q  <= mask_d;
         mode_q  <= mode_d;
         pend_q  <= pend_d;
         state_q <= state_d;
         int_q   <= int_d;
         vec_q   <= vec_d;
      end
   end

   always_comb begin
      cfg_rdata_o = '0;
      unique case (cfg_addr_i)
         ADDR_MASK:   cfg_rdata_o = mask_q;
         ADDR_MODE:   cfg_rdata_o = mode_q;
         ADDR_PEND:   cfg_rdata_o = pend_view;
         ADDR_STATUS: cfg_rdata_o[VEC_W+1:0] = {state_q, vec_q};
         default:     cfg_rdata_o = '0;
      endcase
   end

   assign int_o     = int_q;
   assign int_vec_o = vec_q;

endmodule

// File: tb/tb_up_int_ctrl.sv
// Directed bench for up_int_ctrl: a vector table for the basic edge/priority flows plus
// hand-written sequences for masking, level withdraw, collisions and async reset.
module tb_up_int_ctrl;

   logic       clk_i = 1'b0;
   logic       nrst_i;
   logic [7:0] irq_i;
   logic       cfg_we_i;
   logic [1:0] cfg_addr_i;
   logic [7:0] cfg_wdata_i;
   logic [7:0] cfg_rdata_o;
   logic       int_o;
   logic [2:0] int_vec_o;
   logic       int_ack_i;
   logic       eoi_i;

   int checks   = 0;
   int failures = 0;

   up_int_ctrl #(.N_IRQ(8), .VEC_W(3), .SYNC_STAGES(2)) dut (
      .clk_i       (clk_i),
      .nrst_i      (nrst_i),
      .irq_i       (irq_i),
      .cfg_we_i    (cfg_we_i),
      .cfg_addr_i  (cfg_addr_i),
      .cfg_wdata_i (cfg_wdata_i),
      .cfg_rdata_o (cfg_rdata_o),
      .int_o       (int_o),
      .int_vec_o   (int_vec_o),
      .int_ack_i   (int_ack_i),
      .eoi_i       (eoi_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       we;
      logic [1:0] addr;
      logic [7:0] wd;
      logic [7:0] irq;
      logic       ack;
      logic       eoi;
      logic [1:0] raddr;
      logic [7:0] exp_rd;
      logic       exp_int;
      logic [2:0] exp_vec;
   } vec_t;

   vec_t tbl [23];

   function automatic vec_t mk(input logic we, input logic [1:0] addr, input logic [7:0] wd,
                               input logic [7:0] irq, input logic ack, input logic eoi,
                               input logic [1:0] raddr, input logic [7:0] exp_rd,
                               input logic exp_int, input logic [2:0] exp_vec);
      vec_t v;
      v.we = we; v.addr = addr; v.wd = wd; v.irq = irq; v.ack = ack; v.eoi = eoi;
      v.raddr = raddr; v.exp_rd = exp_rd; v.exp_int = exp_int; v.exp_vec = exp_vec;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic cfg_wr(input logic [1:0] a, input logic [7:0] d);
      cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
      step();
      cfg_we_i = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [1:0] a, input logic [7:0] exp);
      cfg_addr_i = a;
      #1;
      chk(nm, cfg_rdata_o, exp);
   endtask

   task automatic pulse_ack();
      int_ack_i = 1'b1; step(); int_ack_i = 1'b0;
   endtask

   task automatic pulse_eoi();
      eoi_i = 1'b1; step(); eoi_i = 1'b0;
   endtask

   task automatic wait_int(input logic val, input int max, input string nm);
      int n = 0;
      while (int_o !== val && n < max) begin
         step();
         n++;
      end
      chk(nm, int_o, val);
   endtask

   initial begin
      // Edge flow on line 2, then priority between lines 5 and 1.
      tbl[0]  = mk(1, 2'd0, 8'h04, 8'h00, 0, 0, 2'd0, 8'h04, 0, 3'd0);
      tbl[1]  = mk(1, 2'd1, 8'h04, 8'h00, 0, 0, 2'd1, 8'h04, 0, 3'd0);
      tbl[2]  = mk(0, 2'd0, 8'h00, 8'h04, 0, 0, 2'd2, 8'h00, 0, 3'd0);
      tbl[3]  = mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 2'd2, 8'h00, 0, 3'd0);
      tbl[4]  = mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 2'd2, 8'h00, 0, 3'd0);
      tbl[5]  = mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 2'd2, 8'h04, 0, 3'd0);
      tbl[6]  = mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 2'd3, 8'h0A, 1, 3'd2);
      tbl[7]  = mk(0, 2'd0, 8'h00, 8'h00, 1, 0, 2'd2, 8'h00, 0, 3'd2);
      tbl[8]  = mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 2'd3, 8'h12, 0, 3'd2);
      tbl[9]  = mk(0, 2'd0, 8'h00, 8'h00, 0, 1, 2'd3, 8'h02, 0, 3'd2);
      tbl[10] = mk(0, 2'd0, 8'h00, 8'h00, 1, 0, 2'd3, 8'h02, 0, 3'd2);
      tbl[11] = mk(1, 2'd0, 8'hFF, 8'h00, 0, 0, 2'd0, 8'hFF, 0, 3'd2);
      tbl[12] = mk(1, 2'd1, 8'hFF, 8'h00, 0, 0, 2'd1, 8'hFF, 0, 3'd2);
      tbl[13] = mk(0, 2'd0, 8'h00, 8'h22, 0, 0, 2'd2, 8'h00, 0, 3'd2);
      tbl[14] = mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 2'd2, 8'h00, 0, 3'd2);
      tbl[15] = mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 2'd2, 8'h00, 0, 3'd2);
      tbl[16] = mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 2'd2, 8'h22, 0, 3'd2);
      tbl[17] = mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 2'd3, 8'h09, 1, 3'd1);
      tbl[18] = mk(0, 2'd0, 8'h00, 8'h00, 1, 0, 2'd2, 8'h20, 0, 3'd1);
      tbl[19] = mk(0, 2'd0, 8'h00, 8'h00, 0, 1, 2'd3, 8'h01, 0, 3'd1);
      tbl[20] = mk(0, 2'd0, 8'h00, 8'h00, 0, 0, 2'd3, 8'h0D, 1, 3'd5);
      tbl[21] = mk(0, 2'd0, 8'h00, 8'h00, 1, 0, 2'd2, 8'h00, 0, 3'd5);
      tbl[22] = mk(0, 2'd0, 8'h00, 8'h00, 0, 1, 2'd3, 8'h05, 0, 3'd5);

      irq_i = '0; cfg_we_i = 0; cfg_addr_i = 0; cfg_wdata_i = '0; int_ack_i = 0; eoi_i = 0;
      nrst_i = 1'b1;
      #1 nrst_i = 1'b0;
      #1;
      chk("reset_int", int_o, 1'b0);
      chk("reset_vec", int_vec_o, 3'd0);
      rd_chk("reset_status", 2'd3, 8'h00);
      repeat (2) @(posedge clk_i);
      #2 nrst_i = 1'b1;
      step();

      for (int i = 0; i < 23; i++) begin
         cfg_we_i = tbl[i].we; cfg_addr_i = tbl[i].addr; cfg_wdata_i = tbl[i].wd;
         irq_i = tbl[i].irq; int_ack_i = tbl[i].ack; eoi_i = tbl[i].eoi;
         step();
         cfg_we_i = 0; int_ack_i = 0; eoi_i = 0; cfg_addr_i = tbl[i].raddr;
         #1;
         chk($sformatf("tbl%0d_rdata", i), cfg_rdata_o, tbl[i].exp_rd);
         chk($sformatf("tbl%0d_int", i), int_o, tbl[i].exp_int);
         chk($sformatf("tbl%0d_vec", i), int_vec_o, tbl[i].exp_vec);
      end

      // Masked pending edge on line 0, W1C clear, re-latch, then unmask.
      cfg_wr(2'd0, 8'h00);
      irq_i = 8'h01; step(); irq_i = 8'h00; step(); step(); step();
      rd_chk("masked_pend", 2'd2, 8'h01);
      step();
      chk("masked_no_int", int_o, 1'b0);
      cfg_wr(2'd2, 8'h01);
      rd_chk("w1c_clear", 2'd2, 8'h00);
      irq_i = 8'h01; step(); irq_i = 8'h00; step(); step(); step();
      rd_chk("relatch_pend", 2'd2, 8'h01);
      cfg_wr(2'd0, 8'h01);
      wait_int(1'b1, 4, "unmask_int");
      chk("unmask_vec", int_vec_o, 3'd0);
      pulse_ack(); pulse_eoi();

      // Level line 3: tracked not latched, W1C ignored, withdraw when it drops.
      cfg_wr(2'd1, 8'h00);
      cfg_wr(2'd0, 8'h08);
      irq_i = 8'h08;
      repeat (4) step();
      chk("level_int", int_o, 1'b1);
      chk("level_vec", int_vec_o, 3'd3);
      cfg_wr(2'd2, 8'h08);
      rd_chk("level_w1c_ignored", 2'd2, 8'h08);
      step();
      irq_i = 8'h00;
      wait_int(1'b0, 6, "level_withdraw");
      rd_chk("level_idle_status", 2'd3, 8'h03);

      // Ack and withdraw in the same cycle: ack wins.
      irq_i = 8'h08;
      wait_int(1'b1, 6, "coll_req");
      cfg_wr(2'd0, 8'h00);
      chk("coll_still_req", int_o, 1'b1);
      pulse_ack();
      rd_chk("coll_serv_status", 2'd3, 8'h13);
      chk("coll_serv_int", int_o, 1'b0);
      irq_i = 8'h00;

      // New edge on line 4 during service stays pending until eoi.
      cfg_wr(2'd0, 8'h10);
      cfg_wr(2'd1, 8'h10);
      irq_i = 8'h10; step(); irq_i = 8'h00;
      repeat (5) step();
      chk("serv_hold_int", int_o, 1'b0);
      rd_chk("serv_hold_status", 2'd3, 8'h13);
      rd_chk("serv_hold_pend", 2'd2, 8'h10);
      pulse_eoi();
      wait_int(1'b1, 3, "after_eoi_int");
      chk("after_eoi_vec", int_vec_o, 3'd4);
      pulse_ack();
      rd_chk("ack_clears_pend", 2'd2, 8'h00);

      // W1C lands in the same cycle as the edge set: set wins.
      irq_i = 8'h10; step(); irq_i = 8'h00; step(); step();
      cfg_wr(2'd2, 8'h10);
      rd_chk("w1c_vs_set", 2'd2, 8'h10);

      // Async reset in the middle of REQ.
      pulse_eoi();
      wait_int(1'b1, 3, "pre_reset_req");
      #2 nrst_i = 1'b0;
      #1;
      chk("midreset_int", int_o, 1'b0);
      chk("midreset_vec", int_vec_o, 3'd0);
      rd_chk("midreset_mask", 2'd0, 8'h00);
      rd_chk("midreset_mode", 2'd1, 8'h00);
      rd_chk("midreset_pend", 2'd2, 8'h00);
      rd_chk("midreset_status", 2'd3, 8'h00);
      #3 nrst_i = 1'b1;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
